// File: rtl/lemming_status_monitor.sv
// lemming_status_monitor
//
// Watches the one-hot status outputs of a lemming walker FSM and keeps a
// running record of what the lemming has been doing. It tracks the length of
// the most recent fall, whether a fall was fatal, how many times the walk
// direction reversed and how many digs were started. Every output is a
// flop; nothing combinational reaches a port.
//
// Optional feature: define LEMMING_MON_ONEHOT_CHECK_EN to build the status
// encoding checker that drives onehot_err. Without it, onehot_err is tied to
// 0 and no checker logic exists.
//
// Parameter
//   SPLAT_LIMIT  longest fall, in cycles, that is survived (1..30)
//
// Ports
//   clk          clock; all state changes on its rising edge
//   reset        synchronous, active-high reset
//   walk_left    upstream status: walking left
//   walk_right   upstream status: walking right
//   aaah         upstream status: falling
//   digging      upstream status: digging
//   alive        1 until a fatal fall lands
//   splat        sticky flag, set when a fatal fall lands
//   fall_len     length in cycles of the most recently completed fall (sat. 31)
//   turn_count   walk-direction reversals, wraps 255 -> 0
//   dig_count    digs started, saturates at 255
//   onehot_err   1 for each sample whose status inputs are not one-hot
//   state_dbg    current monitor state (0 WALK, 1 FALL, 2 DIG, 3 DEAD)
//
// Handshake: there is none. The upstream status lines are level signals that
// are sampled on every rising edge; no valid/ready pairing applies.

module lemming_status_monitor #(
    parameter int SPLAT_LIMIT = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       walk_left,
    input  logic       walk_right,
    input  logic       aaah,
    input  logic       digging,
    output logic       alive,
    output logic       splat,
    output logic [4:0] fall_len,
    output logic [7:0] turn_count,
    output logic [7:0] dig_count,
    output logic       onehot_err,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        WALK = 2'd0,
        FALL = 2'd1,
        DIG  = 2'd2,
        DEAD = 2'd3
    } state_t;

    localparam logic [4:0] SPLAT_LIM5 = 5'(SPLAT_LIMIT);

    state_t     state;
    state_t     state_d;

    logic [4:0] fcnt;
    logic [4:0] fcnt_d;
    logic       prev_left;
    logic       prev_right;
    logic       prev_dig;

    logic       alive_d;
    logic       splat_d;
    logic [4:0] fall_len_d;
    logic [7:0] turn_count_d;
    logic [7:0] dig_count_d;
    logic       prev_left_d;
    logic       prev_right_d;
    logic       prev_dig_d;

    // Being in FALL means the previous sample had aaah=1, so a current sample
    // with aaah=0 is the landing.
    logic       landing;
    logic       fatal_landing;
    logic       reversal;

    assign landing       = (state == FALL) && !aaah;
    assign fatal_landing = landing && (fcnt > SPLAT_LIM5);

    // Only a direct walk-to-walk flip counts. Requiring the previous state to
    // be WALK and the current sample to be neither falling nor digging keeps
    // reversals that pass through FALL or DIG out of the count.
    assign reversal = (state == WALK) && !aaah && !digging &&
                      ((prev_left && walk_right) || (prev_right && walk_left));

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WALK;
        end else begin
            state <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        if (state != DEAD) begin
            if (fatal_landing) begin
                state_d = DEAD;
            end else if (aaah) begin
                state_d = FALL;
            end else if (digging) begin
                state_d = DIG;
            end else begin
                state_d = WALK;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output / counter next values. DEAD freezes everything by leaving
    // every *_d at its current value.
    // ------------------------------------------------------------------
    always_comb begin
        fcnt_d       = fcnt;
        alive_d      = alive;
        splat_d      = splat;
        fall_len_d   = fall_len;
        turn_count_d = turn_count;
        dig_count_d  = dig_count;
        prev_left_d  = prev_left;
        prev_right_d = prev_right;
        prev_dig_d   = prev_dig;

        if (state != DEAD) begin
            prev_left_d  = walk_left;
            prev_right_d = walk_right;
            prev_dig_d   = digging;

            if (aaah) begin
                if (fcnt != 5'd31) begin
                    fcnt_d = fcnt + 5'd1;
                end
            end else begin
                fcnt_d = 5'd0;
            end

            if (landing) begin
                fall_len_d = fcnt;
            end

            if (fatal_landing) begin
                splat_d = 1'b1;
                alive_d = 1'b0;
            end

            if (reversal) begin
                turn_count_d = turn_count + 8'd1;
            end

            // A landing straight into digging also lands here as a dig start.
            if (digging && !prev_dig && (dig_count != 8'd255)) begin
                dig_count_d = dig_count + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt       <= 5'd0;
            alive      <= 1'b1;
            splat      <= 1'b0;
            fall_len   <= 5'd0;
            turn_count <= 8'd0;
            dig_count  <= 8'd0;
            prev_left  <= 1'b1;
            prev_right <= 1'b0;
            prev_dig   <= 1'b0;
        end else begin
            fcnt       <= fcnt_d;
            alive      <= alive_d;
            splat      <= splat_d;
            fall_len   <= fall_len_d;
            turn_count <= turn_count_d;
            dig_count  <= dig_count_d;
            prev_left  <= prev_left_d;
            prev_right <= prev_right_d;
            prev_dig   <= prev_dig_d;
        end
    end

    // ------------------------------------------------------------------
    // Status encoding checker. Runs in every state, DEAD included, and
    // feeds nothing but onehot_err.
    // ------------------------------------------------------------------
`ifdef LEMMING_MON_ONEHOT_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            onehot_err <= 1'b0;
        end else begin
            onehot_err <= !$onehot({walk_left, walk_right, aaah, digging});
        end
    end
`else
    assign onehot_err = 1'b0;
`endif

endmodule
